clint: RTL and testbench

- Core-local interruptor; the downstream target of the bus block's CLINT port.
- Consumes the offset-relative read and write requests the bus decodes from the store-buffer port.
- Holds the RV32 machine timer (mtime), the compare register (mtimecmp) and the software-interrupt bit (msip).
- Drives the machine timer and software interrupt lines to the core's CSR/interrupt logic.

---
 rtl/clint_pkg.sv | 76 +++++++
 rtl/clint_timer.sv | 80 ++++++++
 rtl/clint.sv | 133 +++++++++++++
 tb/tb_clint.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: bus widths, register
// offsets, access-size encodings and the byte-lane helpers.
package clint_pkg;

  localparam int ADDR_WIDTH     = 16;
  localparam int SIZE_WIDTH     = 3;
  localparam int REG_DATA_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] CLINT_MSIP_OFS     = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] CLINT_MTIMECMP_OFS = 16'h4000;
  localparam logic [ADDR_WIDTH-1:0] CLINT_MTIME_OFS    = 16'hBFF8;

  localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 3'd1;
  localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 3'd2;
  localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 3'd4;

  // Word-granular register selector produced by the address decoder.
  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_MSIP    = 3'd1,
    REG_CMP_LO  = 3'd2,
    REG_CMP_HI  = 3'd3,
    REG_TIME_LO = 3'd4,
    REG_TIME_HI = 3'd5
  } clint_reg_e;

  // Byte strobe for an access; a misaligned or badly sized access yields 0.
  function automatic logic [3:0] byte_mask(input logic [SIZE_WIDTH-1:0] size,
                                           input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << addr;
      SIZE_HALF: mask = addr[0] ? 4'b0000 : (4'b0011 << addr);
      SIZE_WORD: mask = (addr == 2'b00) ? 4'b1111 : 4'b0000;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Map a byte offset to the 32-bit register word it falls in.
  function automatic clint_reg_e decode_reg(input logic [ADDR_WIDTH-1:0] addr);
    clint_reg_e sel;
    if (addr[ADDR_WIDTH-1:2] == CLINT_MSIP_OFS[ADDR_WIDTH-1:2]) begin
      sel = REG_MSIP;
    end else if (addr[ADDR_WIDTH-1:2] == CLINT_MTIMECMP_OFS[ADDR_WIDTH-1:2]) begin
      sel = REG_CMP_LO;
    end else if (addr[ADDR_WIDTH-1:2] == (CLINT_MTIMECMP_OFS[ADDR_WIDTH-1:2] + 14'd1)) begin
      sel = REG_CMP_HI;
    end else if (addr[ADDR_WIDTH-1:2] == CLINT_MTIME_OFS[ADDR_WIDTH-1:2]) begin
      sel = REG_TIME_LO;
    end else if (addr[ADDR_WIDTH-1:2] == (CLINT_MTIME_OFS[ADDR_WIDTH-1:2] + 14'd1)) begin
      sel = REG_TIME_HI;
    end else begin
      sel = REG_NONE;
    end
    return sel;
  endfunction

  // Replace the strobed bytes of a word with the matching bytes of data.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = data[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaler, 64-bit mtime, 64-bit mtimecmp and the
// registered timer-interrupt compare. Writes arrive as per-word byte strobes
// with lane-aligned data.
module clint_timer
  import clint_pkg::*;
#(
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmp_lo_be,
  input  logic [3:0]  cmp_hi_be,
  input  logic [3:0]  time_lo_be,
  input  logic [3:0]  time_hi_be,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] presc_r;
  logic        tick_s;
  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        mtip_r;
  logic [31:0] lo_inc_s;
  logic        carry_s;
  logic [31:0] time_lo_nxt_s;
  logic [31:0] time_hi_nxt_s;
  logic [31:0] cmp_lo_nxt_s;
  logic [31:0] cmp_hi_nxt_s;

  // Terminal count of the prescaler marks a timer tick.
  always_comb begin
    tick_s = (presc_r == TICK_LAST);
  end

  // Prescaler counts 0..TICK_DIV-1 and wraps on the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= 16'h0000;
    end else if (tick_s) begin
      presc_r <= 16'h0000;
    end else begin
      presc_r <= presc_r + 16'h0001;
    end
  end

  // Next mtime/mtimecmp: written bytes override the incremented value, and
  // the low-word carry is added on top of the high word even when written.
  always_comb begin
    lo_inc_s      = mtime_r[31:0] + {31'b0, tick_s};
    carry_s       = tick_s & (mtime_r[31:0] == 32'hFFFF_FFFF);
    time_lo_nxt_s = merge_word(lo_inc_s, wdata, time_lo_be);
    time_hi_nxt_s = merge_word(mtime_r[63:32], wdata, time_hi_be) + {31'b0, carry_s};
    cmp_lo_nxt_s  = merge_word(mtimecmp_r[31:0], wdata, cmp_lo_be);
    cmp_hi_nxt_s  = merge_word(mtimecmp_r[63:32], wdata, cmp_hi_be);
  end

  // Timer state registers and the interrupt compare on current values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_r    <= 64'h0;
      mtimecmp_r <= MTIMECMP_RST;
      mtip_r     <= 1'b0;
    end else begin
      mtime_r    <= {time_hi_nxt_s, time_lo_nxt_s};
      mtimecmp_r <= {cmp_hi_nxt_s, cmp_lo_nxt_s};
      mtip_r     <= (mtime_r >= mtimecmp_r);
    end
  end

  assign mtime    = mtime_r;
  assign mtimecmp = mtimecmp_r;
  assign mtip     = mtip_r;

endmodule

// File: rtl/clint.sv
// Core-local interruptor top: decodes bus offsets, holds msip, routes write
// strobes into the timer and registers read data for the bus.
module clint
  import clint_pkg::*;
#(
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_rd,
  input  logic                      bus_clint_wr,
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      clint_msip,
  output logic                      clint_mtip
);

  clint_reg_e  wr_sel_s;
  clint_reg_e  rd_sel_s;
  logic [3:0]  wr_be_s;
  logic [3:0]  rd_be_s;
  logic [31:0] wdata_s;
  logic [3:0]  cmp_lo_be_s;
  logic [3:0]  cmp_hi_be_s;
  logic [3:0]  time_lo_be_s;
  logic [3:0]  time_hi_be_s;
  logic        msip_we_s;
  logic        msip_r;
  logic [63:0] mtime_s;
  logic [63:0] mtimecmp_s;
  logic        mtip_s;
  logic [31:0] rd_word_s;
  logic [31:0] rd_shift_s;
  logic [31:0] rd_data_s;
  logic [31:0] bus_data_r;

  // Write decode: lane-align the data and steer byte strobes to one word.
  always_comb begin
    wr_sel_s     = decode_reg(bus_clint_write_addr);
    wdata_s      = bus_clint_data << {bus_clint_write_addr[1:0], 3'b000};
    cmp_lo_be_s  = 4'b0000;
    cmp_hi_be_s  = 4'b0000;
    time_lo_be_s = 4'b0000;
    time_hi_be_s = 4'b0000;
    msip_we_s    = 1'b0;
    if (bus_clint_wr) begin
      wr_be_s = byte_mask(bus_clint_write_size, bus_clint_write_addr[1:0]);
    end else begin
      wr_be_s = 4'b0000;
    end
    case (wr_sel_s)
      REG_MSIP:    msip_we_s    = wr_be_s[0];
      REG_CMP_LO:  cmp_lo_be_s  = wr_be_s;
      REG_CMP_HI:  cmp_hi_be_s  = wr_be_s;
      REG_TIME_LO: time_lo_be_s = wr_be_s;
      REG_TIME_HI: time_hi_be_s = wr_be_s;
      default:     msip_we_s    = 1'b0;
    endcase
  end

  // Software interrupt bit; only byte 0 bit 0 of the word is implemented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip_r <= 1'b0;
    end else if (msip_we_s) begin
      msip_r <= wdata_s[0];
    end else begin
      msip_r <= msip_r;
    end
  end

  clint_timer #(
    .TICK_DIV     (TICK_DIV),
    .MTIMECMP_RST (MTIMECMP_RST)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .cmp_lo_be  (cmp_lo_be_s),
    .cmp_hi_be  (cmp_hi_be_s),
    .time_lo_be (time_lo_be_s),
    .time_hi_be (time_hi_be_s),
    .wdata      (wdata_s),
    .mtime      (mtime_s),
    .mtimecmp   (mtimecmp_s),
    .mtip       (mtip_s)
  );

  // Read mux on pre-write register values, shifted and size-truncated.
  always_comb begin
    rd_sel_s = decode_reg(bus_clint_read_addr);
    rd_be_s  = byte_mask(bus_clint_read_size, bus_clint_read_addr[1:0]);
    case (rd_sel_s)
      REG_MSIP:    rd_word_s = {31'b0, msip_r};
      REG_CMP_LO:  rd_word_s = mtimecmp_s[31:0];
      REG_CMP_HI:  rd_word_s = mtimecmp_s[63:32];
      REG_TIME_LO: rd_word_s = mtime_s[31:0];
      REG_TIME_HI: rd_word_s = mtime_s[63:32];
      default:     rd_word_s = 32'h0000_0000;
    endcase
    rd_shift_s = rd_word_s >> {bus_clint_read_addr[1:0], 3'b000};
    if (rd_be_s == 4'b0000) begin
      rd_data_s = 32'h0000_0000;
    end else begin
      case (bus_clint_read_size)
        SIZE_BYTE: rd_data_s = {24'h00_0000, rd_shift_s[7:0]};
        SIZE_HALF: rd_data_s = {16'h0000, rd_shift_s[15:0]};
        SIZE_WORD: rd_data_s = rd_shift_s;
        default:   rd_data_s = 32'h0000_0000;
      endcase
    end
  end

  // Read data register; holds until the next read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_data_r <= 32'h0000_0000;
    end else if (bus_clint_rd) begin
      bus_data_r <= rd_data_s;
    end else begin
      bus_data_r <= bus_data_r;
    end
  end

  assign clint_bus_data = bus_data_r;
  assign clint_msip     = msip_r;
  assign clint_mtip     = mtip_s;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: directed scenarios plus random traffic,
// compared each cycle against a byte-addressed behavioural model.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] raddr, waddr;
  logic [2:0]  rsize, wsize;
  logic [31:0] wdata;
  logic        rd, wr;
  logic [31:0] bus_data;
  logic        msip, mtip;

  logic [15:0] d4_raddr, d4_waddr;
  logic [2:0]  d4_rsize, d4_wsize;
  logic [31:0] d4_wdata;
  logic        d4_rd, d4_wr;
  logic [31:0] d4_bus_data;
  logic        d4_msip, d4_mtip;

  always #5 clk = ~clk;

  clint #(.TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst),
    .bus_clint_read_addr(raddr), .bus_clint_write_addr(waddr),
    .bus_clint_read_size(rsize), .bus_clint_write_size(wsize),
    .bus_clint_data(wdata), .bus_clint_rd(rd), .bus_clint_wr(wr),
    .clint_bus_data(bus_data), .clint_msip(msip), .clint_mtip(mtip)
  );

  clint #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .bus_clint_read_addr(d4_raddr), .bus_clint_write_addr(d4_waddr),
    .bus_clint_read_size(d4_rsize), .bus_clint_write_size(d4_wsize),
    .bus_clint_data(d4_wdata), .bus_clint_rd(d4_rd), .bus_clint_wr(d4_wr),
    .clint_bus_data(d4_bus_data), .clint_msip(d4_msip), .clint_mtip(d4_mtip)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [63:0] m_time, m_cmp;
  logic        m_msip, m_mtip;
  logic [31:0] m_rdata;
  int          m4_edges;
  logic [31:0] m4_rdata;
  logic        d4_req;
  logic [15:0] d4_req_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic aligned(input logic [15:0] a, input logic [2:0] s);
    case (s)
      3'd1:    return 1'b1;
      3'd2:    return ~a[0];
      3'd4:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte view of the register map
  function automatic logic [7:0] mbyte(input logic [15:0] b);
    int off;
    off = int'(b);
    if (off == 0) return {7'b0, m_msip};
    if (off >= 32'h4000 && off <= 32'h4007) return m_cmp[(off - 32'h4000)*8 +: 8];
    if (off >= 32'hBFF8 && off <= 32'hBFFF) return m_time[(off - 32'hBFF8)*8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] read_model(input logic [15:0] a, input logic [2:0] s);
    logic [31:0] r;
    r = 32'h0;
    if (aligned(a, s)) begin
      for (int i = 0; i < int'(s); i++) r[i*8 +: 8] = mbyte(a + 16'(i));
    end
    return r;
  endfunction

  // One clock edge of the model, using the inputs the DUT just sampled
  task automatic model_edge();
    logic [63:0] ot, oc, nc, t4;
    logic [31:0] lo, hi;
    logic        carry, nm;
    int          off;
    ot = m_time; oc = m_cmp; nc = m_cmp; nm = m_msip;
    if (rd) m_rdata = read_model(raddr, rsize);
    lo    = ot[31:0] + 32'd1;
    hi    = ot[63:32];
    carry = (ot[31:0] == 32'hFFFF_FFFF);
    if (wr && aligned(waddr, wsize)) begin
      for (int i = 0; i < int'(wsize); i++) begin
        off = int'(waddr) + i;
        if (off == 0) nm = wdata[i*8];
        else if (off >= 32'h4000 && off <= 32'h4007) nc[(off - 32'h4000)*8 +: 8] = wdata[i*8 +: 8];
        else if (off >= 32'hBFF8 && off <= 32'hBFFB) lo[(off - 32'hBFF8)*8 +: 8] = wdata[i*8 +: 8];
        else if (off >= 32'hBFFC && off <= 32'hBFFF) hi[(off - 32'hBFFC)*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    m_mtip = (ot >= oc);
    m_time = {hi + {31'b0, carry}, lo};
    m_cmp  = nc;
    m_msip = nm;
    t4 = 64'(m4_edges / 4);
    if (d4_rd) m4_rdata = (d4_raddr == 16'hBFF8) ? t4[31:0] : ((d4_raddr == 16'hBFFC) ? t4[63:32] : 32'h0);
    m4_edges++;
  endtask

  task automatic step(input logic r, input logic [15:0] ra, input logic [2:0] rs,
                      input logic w, input logic [15:0] wa, input logic [2:0] ws,
                      input logic [31:0] wd);
    @(negedge clk);
    rd = r; raddr = ra; rsize = rs; wr = w; waddr = wa; wsize = ws; wdata = wd;
    d4_rd = d4_req; d4_raddr = d4_req_addr; d4_rsize = 3'd4; d4_req = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check("rdata", bus_data, m_rdata);
    check("msip", msip, m_msip);
    check("mtip", mtip, m_mtip);
    check("d4_rdata", d4_bus_data, m4_rdata);
    check("d4_mtip", d4_mtip, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 3'd4, 1'b0, 16'h0, 3'd4, 32'h0);
  endtask

  task automatic wr32(input logic [15:0] a, input logic [31:0] d);
    step(1'b0, 16'h0, 3'd4, 1'b1, a, 3'd4, d);
  endtask

  task automatic rd_acc(input logic [15:0] a, input logic [2:0] s);
    step(1'b1, a, s, 1'b0, 16'h0, 3'd4, 32'h0);
  endtask

  task automatic model_reset();
    m_time = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0; m_mtip = 1'b0;
    m_rdata = 32'h0; m4_edges = 0; m4_rdata = 32'h0;
  endtask

  // Assert reset away from any edge, check outputs clear asynchronously, release
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_rdata", bus_data, 32'h0);
    check("rst_msip", msip, 1'b0);
    check("rst_mtip", mtip, 1'b0);
    check("rst_d4_rdata", d4_bus_data, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  logic [15:0] bases [7] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0010, 16'h8000};
  logic [2:0]  sizes [6] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd3, 3'd0};

  initial begin
    rd = 1'b0; wr = 1'b0; raddr = 16'h0; waddr = 16'h0; rsize = 3'd4; wsize = 3'd4; wdata = 32'h0;
    d4_rd = 1'b0; d4_wr = 1'b0; d4_raddr = 16'h0; d4_waddr = 16'h0;
    d4_rsize = 3'd4; d4_wsize = 3'd4; d4_wdata = 32'h0;
    d4_req = 1'b0; d4_req_addr = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    do_reset();

    // Prescaled timer: 40 cycles at TICK_DIV=4 gives mtime 10
    idle(40);
    d4_req = 1'b1; d4_req_addr = 16'hBFF8;
    idle(1);
    check("t1_lo_is_10", d4_bus_data, 32'd10);
    d4_req = 1'b1; d4_req_addr = 16'hBFFC;
    idle(1);
    check("t1_hi_is_0", d4_bus_data, 32'd0);

    // Compare crossing and withdrawal
    wr32(16'hBFF8, 32'h0);
    wr32(16'hBFFC, 32'h0);
    wr32(16'h4004, 32'h0);
    wr32(16'h4000, 32'd20);
    idle(25);
    check("t2_mtip_high", mtip, 1'b1);
    wr32(16'h4000, 32'hFFFF_FFFF);
    idle(2);
    check("t2_mtip_low", mtip, 1'b0);

    // Carry from low into high word
    wr32(16'hBFFC, 32'h0);
    wr32(16'hBFF8, 32'hFFFF_FFFF);
    rd_acc(16'hBFF8, 3'd4);
    rd_acc(16'hBFFC, 3'd4);
    check("t3_hi_after_wrap", bus_data, 32'd1);
    wr32(16'hBFF8, 32'hFFFF_FFFF);
    wr32(16'hBFFC, 32'd5);
    rd_acc(16'hBFFC, 3'd4);
    check("t3_hi_carry", bus_data, 32'd6);

    // Full 64-bit wrap
    wr32(16'hBFFC, 32'hFFFF_FFFF);
    wr32(16'hBFF8, 32'hFFFF_FFFE);
    idle(2);
    rd_acc(16'hBFFC, 3'd4);

    // Software interrupt
    wr32(16'h0000, 32'hFFFF_FFFF);
    rd_acc(16'h0000, 3'd4);
    check("t4_msip_read", bus_data, 32'h1);
    wr32(16'h0000, 32'h0);
    idle(1);
    check("t4_msip_clear", msip, 1'b0);

    // Byte lanes and misalignment
    step(1'b0, 16'h0, 3'd4, 1'b1, 16'h4001, 3'd1, 32'h0000_00AB);
    step(1'b0, 16'h0, 3'd4, 1'b1, 16'h4001, 3'd2, 32'h0000_1234);
    rd_acc(16'h4001, 3'd1);
    check("t5_byte_read", bus_data, 32'hAB);
    rd_acc(16'h4002, 3'd2);
    rd_acc(16'h4001, 3'd2);
    check("t5_misaligned_read", bus_data, 32'h0);

    // Same-cycle read and write to the same word
    step(1'b1, 16'h4000, 3'd4, 1'b1, 16'h4000, 3'd4, 32'h1111_2222);
    rd_acc(16'h4000, 3'd4);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra, wa;
      ra = bases[$urandom_range(0, 6)];
      wa = bases[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) ra = ra | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wa = wa | 16'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), ra, sizes[$urandom_range(0, 5)],
           ($urandom_range(0, 2) == 0), wa, sizes[$urandom_range(0, 5)],
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom);
    end

    // Reset while interrupts are pending, then mtime restarts from 0
    wr32(16'h4004, 32'h0);
    wr32(16'h4000, 32'h0);
    wr32(16'h0000, 32'h1);
    rd_acc(16'h0000, 3'd4);
    idle(1);
    check("t6_pre_mtip", mtip, 1'b1);
    #2;
    do_reset();
    idle(5);
    rd_acc(16'hBFF8, 3'd4);
    check("t6_restart", bus_data, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
